// File: rtl/arr_ctrl_mux_if.sv
// Bundle of host-control and kernel-datapath signals for the arr_ctrl_mux array store.
// The master side drives the access strobes; the slave side (the array) returns read data and status.
interface arr_ctrl_mux_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              controlArr;
    logic              controlWEnable;
    logic [ADDR_W-1:0] controlAddr;
    logic [DATA_W-1:0] controlWData;
    logic [DATA_W-1:0] controlRData;
    logic              kWEnable;
    logic              kREnable;
    logic [ADDR_W-1:0] kAddr;
    logic [DATA_W-1:0] kWData;
    logic [DATA_W-1:0] kRData;
    logic              kRValid;
    logic              kGrant;
    logic              busy;

    modport master (
        output controlArr, controlWEnable, controlAddr, controlWData,
        output kWEnable, kREnable, kAddr, kWData,
        input  controlRData, kRData, kRValid, kGrant, busy
    );

    modport slave (
        input  controlArr, controlWEnable, controlAddr, controlWData,
        input  kWEnable, kREnable, kAddr, kWData,
        output controlRData, kRData, kRValid, kGrant, busy
    );
endinterface

// File: rtl/arr_ctrl_mux.sv
// DEPTH x DATA_W register-file array shared between the kernel datapath and the host port,
// with an optional post-reset clear sequencer that walks every entry to CLEAR_VAL.
module arr_ctrl_mux #(
    parameter int                DATA_W         = 8,
    parameter int                ADDR_W         = 4,
    parameter int                DEPTH          = 16,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
    input  logic          clk,
    input  logic          r_enable,
    arr_ctrl_mux_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              host_sel;
    logic              kern_sel;
    logic              kern_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    assign host_sel    = (state == ST_IDLE) && bus.controlArr;
    assign kern_sel    = (state == ST_IDLE) && !bus.controlArr;
    assign kern_rd     = kern_sel && bus.kREnable && !bus.kWEnable;
    assign bus.kGrant  = kern_sel;
    assign bus.busy    = (state == ST_CLEAR);

    // Clear sequencer owns the write port outright; otherwise the current owner does.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.kAddr;
        wr_data = bus.kWData;
        if (state == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_ptr;
            wr_data = CLEAR_VAL;
        end else if (host_sel) begin
            wr_en   = bus.controlWEnable;
            wr_addr = bus.controlAddr;
            wr_data = bus.controlWData;
        end else begin
            wr_en   = bus.kWEnable;
        end
    end

    assign rd_addr = host_sel ? bus.controlAddr : bus.kAddr;
    assign rd_data = in_range(rd_addr) ? mem[rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en && !r_enable && in_range(wr_addr)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (r_enable) begin
            state            <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr          <= '0;
            bus.controlRData <= '0;
            bus.kRData       <= '0;
            bus.kRValid      <= 1'b0;
        end else begin
            bus.kRValid <= kern_rd;
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST) begin
                        state   <= ST_IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (host_sel && !bus.controlWEnable) begin
                        bus.controlRData <= rd_data;
                    end
                    if (kern_rd) begin
                        bus.kRData <= rd_data;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arr_ctrl_mux.sv
// Bench for arr_ctrl_mux: a full-depth instance (DEPTH=16, CLEAR_VAL=5A) and a short one (DEPTH=12)
// checked every cycle against an array-level model, plus directed literal expectations.
module tb_arr_ctrl_mux;
    logic clk = 1'b0;
    logic r0  = 1'b1;
    logic r1  = 1'b1;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    arr_ctrl_mux_if #(.DATA_W(8), .ADDR_W(4)) bus0 ();
    arr_ctrl_mux_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();

    arr_ctrl_mux #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'h5A))
        u_dut0 (.clk(clk), .r_enable(r0), .bus(bus0.slave));
    arr_ctrl_mux #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'h00))
        u_dut1 (.clk(clk), .r_enable(r1), .bus(bus1.slave));

    // Array-level model: clr_left counts remaining entries to clear; words live in a plain array.
    logic [7:0] exp_mem [2][16];
    logic [7:0] exp_crd [2];
    logic [7:0] exp_krd [2];
    logic       exp_kv  [2];
    int         clr_left[2] = '{0, 0};

    task automatic model_step(input int k, input logic rst, input logic ca, input logic cwe,
                              input logic [3:0] caddr, input logic [7:0] cwd,
                              input logic kwe, input logic kre,
                              input logic [3:0] kaddr, input logic [7:0] kwd);
        int d = (k == 0) ? 16 : 12;
        logic [7:0] cv = (k == 0) ? 8'h5A : 8'h00;
        if (rst) begin
            exp_crd[k] = 8'h00;
            exp_krd[k] = 8'h00;
            exp_kv[k]  = 1'b0;
            clr_left[k] = d;
            return;
        end
        exp_kv[k] = 1'b0;
        if (clr_left[k] > 0) begin
            exp_mem[k][d - clr_left[k]] = cv;
            clr_left[k] = clr_left[k] - 1;
        end else if (ca) begin
            if (cwe) begin
                if (int'(caddr) < d) exp_mem[k][caddr] = cwd;
            end else begin
                exp_crd[k] = (int'(caddr) < d) ? exp_mem[k][caddr] : 8'h00;
            end
        end else if (kwe) begin
            if (int'(kaddr) < d) exp_mem[k][kaddr] = kwd;
        end else if (kre) begin
            exp_krd[k] = (int'(kaddr) < d) ? exp_mem[k][kaddr] : 8'h00;
            exp_kv[k]  = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, r0, bus0.controlArr, bus0.controlWEnable, bus0.controlAddr, bus0.controlWData,
                   bus0.kWEnable, bus0.kREnable, bus0.kAddr, bus0.kWData);
        model_step(1, r1, bus1.controlArr, bus1.controlWEnable, bus1.controlAddr, bus1.controlWData,
                   bus1.kWEnable, bus1.kREnable, bus1.kAddr, bus1.kWData);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0 busy",  32'(bus0.busy),         32'(clr_left[0] > 0));
            chk("d0 grant", 32'(bus0.kGrant),       32'(!bus0.controlArr && clr_left[0] == 0));
            chk("d0 crd",   32'(bus0.controlRData), 32'(exp_crd[0]));
            chk("d0 krd",   32'(bus0.kRData),       32'(exp_krd[0]));
            chk("d0 kv",    32'(bus0.kRValid),      32'(exp_kv[0]));
            chk("d1 busy",  32'(bus1.busy),         32'(clr_left[1] > 0));
            chk("d1 grant", 32'(bus1.kGrant),       32'(!bus1.controlArr && clr_left[1] == 0));
            chk("d1 crd",   32'(bus1.controlRData), 32'(exp_crd[1]));
            chk("d1 krd",   32'(bus1.kRData),       32'(exp_krd[1]));
            chk("d1 kv",    32'(bus1.kRValid),      32'(exp_kv[1]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus0.controlArr = 0; bus0.controlWEnable = 0; bus0.controlAddr = 0; bus0.controlWData = 0;
        bus0.kWEnable = 0; bus0.kREnable = 0; bus0.kAddr = 0; bus0.kWData = 0;
        bus1.controlArr = 0; bus1.controlWEnable = 0; bus1.controlAddr = 0; bus1.controlWData = 0;
        bus1.kWEnable = 0; bus1.kREnable = 0; bus1.kAddr = 0; bus1.kWData = 0;

        step();
        chk_en = 1'b1;
        r0 = 0; r1 = 0;
        chk("rst crd", 32'(bus0.controlRData), 32'h0);
        chk("rst kv",  32'(bus0.kRValid), 32'h0);

        n = 0;
        while (bus0.busy && n < 40) begin n++; step(); end
        chk("clear length", n, 16);

        bus0.controlArr = 1;
        for (int i = 0; i < 16; i++) begin
            bus0.controlAddr = 4'(i);
            step();
            chk("clear val", 32'(bus0.controlRData), 32'h5A);
        end

        // host write then read, kernel strobes ignored
        bus0.kREnable = 1; bus0.kAddr = 3;
        bus0.controlWEnable = 1; bus0.controlAddr = 3; bus0.controlWData = 8'hA5;
        step();
        chk("host wr hold", 32'(bus0.controlRData), 32'h5A);
        bus0.controlWEnable = 0;
        step();
        chk("host rd", 32'(bus0.controlRData), 32'hA5);
        chk("host kv", 32'(bus0.kRValid), 32'h0);
        bus0.kREnable = 0;

        // kernel write wins over same-cycle read
        bus0.controlArr = 0;
        bus0.kWEnable = 1; bus0.kREnable = 1; bus0.kAddr = 5; bus0.kWData = 8'h3C;
        #1 chk("grant", 32'(bus0.kGrant), 32'h1);
        step();
        chk("wr prio kv", 32'(bus0.kRValid), 32'h0);
        bus0.kWEnable = 0;
        step();
        chk("raw krd", 32'(bus0.kRData), 32'h3C);
        chk("raw kv",  32'(bus0.kRValid), 32'h1);
        bus0.kREnable = 0;

        bus0.kWEnable = 1;
        for (int i = 0; i < 3; i++) begin
            bus0.kAddr = 4'(i); bus0.kWData = 8'(i + 1);
            step();
        end
        bus0.kWEnable = 0; bus0.kREnable = 1;
        for (int i = 0; i < 3; i++) begin
            bus0.kAddr = 4'(i);
            step();
            chk("b2b kv",  32'(bus0.kRValid), 32'h1);
            chk("b2b krd", 32'(bus0.kRData), 32'(i + 1));
        end
        // read issued, then host takes the array: the read still completes
        bus0.kAddr = 1;
        step();
        bus0.controlArr = 1; bus0.kREnable = 0;
        #1 chk("switch grant", 32'(bus0.kGrant), 32'h0);
        chk("switch kv",  32'(bus0.kRValid), 32'h1);
        chk("switch krd", 32'(bus0.kRData), 32'h2);
        step();
        chk("switch kv end", 32'(bus0.kRValid), 32'h0);

        // reset mid-clear restarts; kernel writes during clear are dropped
        bus0.controlArr = 0; bus0.kWEnable = 1; bus0.kAddr = 2; bus0.kWData = 8'h77;
        r0 = 1;
        step();
        r0 = 0;
        for (int i = 0; i < 7; i++) begin
            chk("clear busy", 32'(bus0.busy), 32'h1);
            step();
        end
        r0 = 1;
        step();
        r0 = 0;
        n = 0;
        while (bus0.busy && n < 40) begin n++; step(); end
        bus0.kWEnable = 0;
        chk("restart length", n, 16);
        bus0.controlArr = 1; bus0.controlAddr = 2;
        step();
        chk("clear drop", 32'(bus0.controlRData), 32'h5A);
        bus0.controlArr = 0;

        // short array: out-of-range write ignored, read returns 0
        bus1.kWEnable = 1;
        for (int i = 0; i < 12; i++) begin
            bus1.kAddr = 4'(i); bus1.kWData = 8'(8'h10 + i);
            step();
        end
        bus1.kAddr = 13; bus1.kWData = 8'hFF;
        step();
        bus1.kWEnable = 0; bus1.kREnable = 1; bus1.kAddr = 0;
        step();
        chk("d1 rd0", 32'(bus1.kRData), 32'h10);
        bus1.kAddr = 13;
        step();
        chk("oor krd", 32'(bus1.kRData), 32'h0);
        chk("oor kv",  32'(bus1.kRValid), 32'h1);
        for (int i = 0; i < 12; i++) begin
            bus1.kAddr = 4'(i);
            step();
            chk("d1 keep", 32'(bus1.kRData), 32'(8'h10 + i));
        end
        bus1.kREnable = 0;
        bus1.controlArr = 1; bus1.controlAddr = 11;
        step();
        chk("d1 host rd", 32'(bus1.controlRData), 32'h1B);
        bus1.controlAddr = 13;
        step();
        chk("d1 host oor", 32'(bus1.controlRData), 32'h0);
        bus1.controlArr = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
